smart_lighting_top: RTL and testbench
=====================================

# smart_lighting_top

Occupancy-driven lamp controller with a manual override. In automatic mode the lamp output follows a motion sensor and stays on for a fixed hold time after motion stops. A long press on a push button switches between automatic and manual mode. In manual mode a short press toggles the lamp. This is the top level of the lighting design: it connects directly to the board button, the PIR sensor, the mode LED and the lamp driver.

## Interface
Reset: one clock; reset is asynchronous and active-low (`rst`), clock is `clk`.

Parameters:
- `T_OFF_CYCLES`, default 2000: lamp hold time after the last sampled motion, in cycles.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed before the debounced button changes level.
- `LONG_PRESS_CYCLES`, default 300: debounced-press length that toggles the mode.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `push_button`  in  1  raw button, active-high, asynchronous, may bounce.
- `infravermelho`  in  1  PIR motion sensor, active-high, asynchronous.
- `led`  out  1  mode indicator: 1 = manual, 0 = automatic.
- `saida`  out  1  lamp drive, 1 = lamp on.

## Operation
- Reset values: mode = automatic, `led`=0, `saida`=0, all counters 0, synchronizers 0.
- Inputs: both inputs pass through 2-flop synchronizers. The button is also debounced: its debounced level changes only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. The IR input is not debounced.
- Automatic mode, hold timer:
  - Each cycle the synchronized IR is 1, the timer loads `T_OFF_CYCLES`.
  - Otherwise the timer decrements while non-zero.
  - `saida` = (timer != 0), registered.
  - Renewed motion during the hold restarts the full hold time.
- Press tracking, both modes:
  - A press counter counts cycles while the debounced button is 1, saturating at `LONG_PRESS_CYCLES`.
  - When the count reaches `LONG_PRESS_CYCLES`, the mode toggles exactly once per press; holding longer causes no repeat.
  - On a debounced release with count < `LONG_PRESS_CYCLES` (short press):
    - manual mode: `saida` toggles;
    - automatic mode: no effect.
  - The counter clears on release.
- Mode entry:
  - Entering manual: `saida` forced to 0, timer cleared; IR is ignored while in manual mode.
  - Entering automatic: timer cleared, `saida`=0 until the next sampled motion.
- `led` is the registered mode bit.

## Timing
- IR rise to `saida`=1: `saida` rises 3 clock edges after the IR input rises (2 sync edges + 1 register edge).
- IR fall: `saida` stays 1 for `T_OFF_CYCLES` cycles after the last cycle synchronized IR was 1.
- Button press: the debounced level rises 2+`DEBOUNCE_CYCLES` cycles after a clean rise. `led` toggles 1 cycle after the press counter reaches `LONG_PRESS_CYCLES`.
- Short press: `saida` toggles 1 cycle after the debounced release.
- Simultaneous motion and mode toggle in the same cycle: the mode toggle wins, and the mode-entry rules apply.
- Reset asserted mid-hold or mid-press returns everything to reset values immediately, without waiting for a clock edge.
- Counter widths: `$clog2(param+1)` bits; no wrap-around is permitted.

## Structure
- Package `smart_lighting_pkg`: mode enum (`MODE_AUTO`, `MODE_MANUAL`) and default parameter constants.
- One sub-module, `button_debouncer`: 2-flop synchronizer plus stability counter; outputs the debounced level and a one-cycle release pulse.
- The top level holds the IR synchronizer, hold timer, press counter and mode/lamp registers.

## Test plan
Defaults unless stated. Clock period 10 ns.
1. Reset: `rst`=0 for 20 ns -> `led`=0 and `saida`=0 during reset and on release.
2. Motion pulse: IR=1 for 5 cycles -> `saida` rises 3 edges later, and stays 1 until 2000 cycles after the last synchronized IR=1, then 0.
3. Retrigger: IR pulse, then a second pulse 1500 cycles later -> `saida` stays continuously 1 until 2000 cycles after the second pulse.
4. Long press: button held 500 cycles -> `led` goes 1 about 318 cycles after the press, `saida`=0, and a 50-cycle IR pulse leaves `saida`=0.
5. Manual short press: in manual, press 100 cycles -> `saida` toggles to 1 after release; a second identical press toggles it back to 0. Bounce: toggling the raw input every 3 cycles for 12 cycles must produce no press.
6. Return to auto: a second 500-cycle press -> `led`=0, `saida`=0, and the next IR pulse lights the lamp normally.

Source files
------------

// File: rtl/smart_lighting_pkg.sv
// Shared types and default timing constants for the occupancy lamp controller.
package smart_lighting_pkg;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_t;

  localparam int DEF_T_OFF_CYCLES      = 2000;
  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 300;

  function automatic mode_t flip_mode(input mode_t m);
    return (m == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
  endfunction

endpackage

// File: rtl/smart_lighting_top_button.sv
// Button conditioning: 2-flop synchronizer, stability-count debouncer and a
// one-cycle pulse in the cycle after the debounced level falls.
module button_debouncer
  import smart_lighting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_release
);

  localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_release;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_release <= 1'b0;
      // Any cycle where the synchronized input agrees with the level restarts the count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt     <= '0;
        r_level   <= r_sync2;
        r_release <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_release = r_release;

endmodule

// File: rtl/smart_lighting_top.sv
// Occupancy-driven lamp controller: PIR hold timer in automatic mode, long
// press toggles mode, short press toggles the lamp in manual mode.
module smart_lighting_top
  import smart_lighting_pkg::*;
#(
  parameter int T_OFF_CYCLES      = DEF_T_OFF_CYCLES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic led,
  output logic saida
);

  localparam int            TW      = $clog2(T_OFF_CYCLES + 1);
  localparam int            PW      = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [TW-1:0] C_T_OFF = TW'(T_OFF_CYCLES);
  localparam logic [PW-1:0] C_LONG  = PW'(LONG_PRESS_CYCLES);

  logic          r_ir_s1;
  logic          r_ir_s2;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_press_cnt;
  logic          r_long_fired;
  mode_t         r_mode;
  logic          r_saida;

  logic          w_btn_level;
  logic          w_btn_release;
  logic          w_mode_toggle;
  logic          w_short_press;
  mode_t         w_mode_next;
  logic [TW-1:0] w_timer_next;
  logic          w_saida_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (push_button),
    .o_level  (w_btn_level),
    .o_release(w_btn_release)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir_s1 <= 1'b0;
      r_ir_s2 <= 1'b0;
    end else begin
      r_ir_s1 <= infravermelho;
      r_ir_s2 <= r_ir_s1;
    end
  end

  // Saturating press length; the fired flag limits the mode toggle to once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press_cnt  <= '0;
      r_long_fired <= 1'b0;
    end else if (!w_btn_level) begin
      r_press_cnt  <= '0;
      r_long_fired <= 1'b0;
    end else begin
      if (r_press_cnt != C_LONG) begin
        r_press_cnt <= r_press_cnt + 1'b1;
      end
      if (w_mode_toggle) begin
        r_long_fired <= 1'b1;
      end
    end
  end

  assign w_mode_toggle = w_btn_level && (r_press_cnt == C_LONG) && !r_long_fired;
  // The count is still held in the release-pulse cycle; it clears on that edge.
  assign w_short_press = w_btn_release && (r_press_cnt < C_LONG);

  always_comb begin
    w_mode_next  = r_mode;
    w_timer_next = r_timer;
    w_saida_next = r_saida;
    if (w_mode_toggle) begin
      w_mode_next  = flip_mode(r_mode);
      w_timer_next = '0;
      w_saida_next = 1'b0;
    end else if (r_mode == MODE_AUTO) begin
      if (r_ir_s2) begin
        w_timer_next = C_T_OFF;
      end else if (r_timer != '0) begin
        w_timer_next = r_timer - 1'b1;
      end
      w_saida_next = (w_timer_next != '0);
    end else begin
      w_timer_next = '0;
      if (w_short_press) begin
        w_saida_next = ~r_saida;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= MODE_AUTO;
      r_timer <= '0;
      r_saida <= 1'b0;
    end else begin
      r_mode  <= w_mode_next;
      r_timer <= w_timer_next;
      r_saida <= w_saida_next;
    end
  end

  assign led   = (r_mode == MODE_MANUAL);
  assign saida = r_saida;

endmodule

// File: tb/tb_smart_lighting_top.sv
// Scoreboard bench: stimulus queues expected output changes (cycle, led, saida);
// a monitor pops and compares on every observed change of the outputs.
module tb_smart_lighting_top;

  logic clk = 1'b0;
  logic rst;
  logic push_button;
  logic infravermelho;
  logic led;
  logic saida;

  int cyc;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int   cyc;
    logic led;
    logic saida;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  smart_lighting_top dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .led          (led),
    .saida        (saida)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic expect_at(input int at, input logic l, input logic s, input string nm);
    exp_t e;
    e.cyc = at;
    e.led = l;
    e.saida = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, got, req);
    end else begin
      $display("ok %s = %b", nm, got);
    end
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected changes still pending (next %s), required 0",
               exp_q.size(), name_q[0]);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic press(input int n);
    push_button = 1'b1;
    repeat (n) @(negedge clk);
    push_button = 1'b0;
  endtask

  task automatic ir_pulse(input int n);
    infravermelho = 1'b1;
    repeat (n) @(negedge clk);
    infravermelho = 1'b0;
  endtask

  initial begin : monitor
    logic [1:0] prev;
    exp_t       e;
    string      nm;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en && ({led, saida} !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cycle %0d got led=%b saida=%b, required led=%b saida=%b",
                   cyc, led, saida, prev[1], prev[0]);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e.cyc != cyc || e.led !== led || e.saida !== saida) begin
            errors++;
            $display("FAIL %s: got cycle %0d led=%b saida=%b, required cycle %0d led=%b saida=%b",
                     nm, cyc, led, saida, e.cyc, e.led, e.saida);
          end else begin
            $display("ok %s: cycle %0d led=%b saida=%b", nm, cyc, led, saida);
          end
        end
        prev = {led, saida};
      end
    end
  end

  initial begin : stimulus
    int c;
    rst = 1'b0;
    push_button = 1'b0;
    infravermelho = 1'b0;
    #12;
    chk("reset_led_during", led, 1'b0);
    chk("reset_saida_during", saida, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_led_after", led, 1'b0);
    chk("reset_saida_after", saida, 1'b0);
    mon_en = 1'b1;

    // Motion pulse of 5 cycles: rise 3 edges later, fall T after the last synchronized 1.
    c = cyc;
    expect_at(c + 3, 1'b0, 1'b1, "t2_rise");
    expect_at(c + 5 + 2 + 2000, 1'b0, 1'b0, "t2_fall");
    ir_pulse(5);
    drain(2100);

    // Retrigger 1500 cycles later keeps the lamp on continuously.
    c = cyc;
    expect_at(c + 3, 1'b0, 1'b1, "t3_rise");
    ir_pulse(5);
    repeat (1495) @(negedge clk);
    expect_at(c + 1500 + 5 + 2 + 2000, 1'b0, 1'b0, "t3_fall");
    ir_pulse(5);
    drain(2100);

    // Long press into manual: debounced at +18, count hits 300 at +318, led at +319.
    c = cyc;
    expect_at(c + 319, 1'b1, 1'b0, "t4_led_on");
    press(500);
    repeat (40) @(negedge clk);
    drain(5);
    chk("t4_led_manual", led, 1'b1);
    ir_pulse(50);
    repeat (20) @(negedge clk);
    chk("t4_ir_ignored", saida, 1'b0);

    // Short presses in manual: release debounced at +118, lamp toggles at +119.
    c = cyc;
    expect_at(c + 119, 1'b1, 1'b1, "t5_short_on");
    press(100);
    repeat (140) @(negedge clk);
    drain(5);
    c = cyc;
    expect_at(c + 119, 1'b1, 1'b0, "t5_short_off");
    press(100);
    repeat (140) @(negedge clk);
    drain(5);

    // Bounce shorter than the debounce window must not register a press.
    for (int i = 0; i < 4; i++) begin
      push_button = ~push_button;
      repeat (3) @(negedge clk);
    end
    push_button = 1'b0;
    repeat (60) @(negedge clk);
    chk("t5_bounce_saida", saida, 1'b0);
    chk("t5_bounce_led", led, 1'b1);

    // Second long press returns to automatic; motion lights the lamp again.
    c = cyc;
    expect_at(c + 319, 1'b0, 1'b0, "t6_led_off");
    press(500);
    repeat (40) @(negedge clk);
    drain(5);
    c = cyc;
    expect_at(c + 3, 1'b0, 1'b1, "t6_rise");
    expect_at(c + 5 + 2 + 2000, 1'b0, 1'b0, "t6_fall");
    ir_pulse(5);
    drain(2100);

    // Asynchronous reset mid-hold clears the lamp without a clock edge.
    c = cyc;
    expect_at(c + 3, 1'b0, 1'b1, "t7_rise");
    ir_pulse(5);
    repeat (10) @(negedge clk);
    drain(5);
    mon_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_async_rst_saida", saida, 1'b0);
    chk("t7_async_rst_led", led, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
